// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared definitions for the two-port data-memory arbiter:
//                parameter defaults, FSM state enumeration and port ids.
//  Contents    : c_DATA_WIDTH_DEFAULT - default data word width
//                c_ADDR_BITS_DEFAULT  - default memory address width
//                arb_state_e          - arbiter FSM states
//                c_PORT0 / c_PORT1    - port identifiers (last-served / winner)
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_DATA_WIDTH_DEFAULT = 8;
    localparam int c_ADDR_BITS_DEFAULT  = 5;

    // Two bits cover three legal states; the fourth code is treated as
    // illegal and steers the FSM back to IDLE.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } arb_state_e;

    localparam logic c_PORT0 = 1'b0;
    localparam logic c_PORT1 = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational 2-way round-robin picker. A lone requester
//                wins outright; on a tie the port that was NOT served last
//                wins.
//  Ports       : req0, req1 (in)  - request lines of port 0 / port 1
//                last       (in)  - port served most recently (0 or 1)
//                winner     (out) - selected port (valid only when valid=1)
//                valid      (out) - at least one request is present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);

    assign valid  = req0 | req1;
    // Tie: invert the last-served pointer. Otherwise port 1 wins only when it
    // is the one asking (winner is don't-care when nothing is asking).
    assign winner = (req0 & req1) ? ~last : req1;

endmodule : rr_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates two requesters (port 0 = control unit, port 1 =
//                loader/host) onto a single synchronous-read data memory.
//                Each access takes three cycles: ACCESS (grant + memory
//                enable), COMPLETE (read data returns), then a done pulse in
//                the following IDLE cycle.
//  Ports       : clk, rst (async, active-low)
//                req0/1, we0/1, addr0/1, wdata0/1  - requester side inputs
//                gnt0/1, done0/1, rdata0/1         - requester side outputs
//                mem_en, mem_w_r, mem_addr, mem_wdata, mem_rdata - memory side
//                busy                              - FSM not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT,
    parameter int ADDR_BITS  = c_ADDR_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_BITS-1:0]  addr0,
    input  logic [ADDR_BITS-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_en,
    output logic                  mem_w_r,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    // ------------------------------------------------------------------
    // State and latched transaction
    // ------------------------------------------------------------------
    arb_state_e              state_q;
    arb_state_e              state_d;
    logic                    last_q;      // port served most recently
    logic                    port_q;      // port owning the current access
    logic                    we_q;
    logic [ADDR_BITS-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    done0_q;
    logic                    done1_q;
    logic [DATA_WIDTH-1:0]   rdata0_q;
    logic [DATA_WIDTH-1:0]   rdata1_q;

    logic                    w_winner;
    logic                    w_valid;
    logic                    w_sample;    // a request is accepted this edge
    logic                    w_complete;  // current cycle is COMPLETE

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    rr_pick u_rr_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .winner (w_winner),
        .valid  (w_valid)
    );

    assign w_sample   = (state_q == IDLE) && w_valid;
    assign w_complete = (state_q == COMPLETE);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and memory/grant outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        mem_en  = 1'b0;
        mem_w_r = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_valid) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_en  = 1'b1;
                mem_w_r = we_q;
                gnt0    = (port_q == c_PORT0);
                gnt1    = (port_q == c_PORT1);
                state_d = COMPLETE;
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction latch and round-robin pointer. The pointer resets to
    // port 1 so that port 0 wins the first tie after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q  <= c_PORT1;
            port_q  <= c_PORT0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (w_sample) begin
            last_q  <= w_winner;
            port_q  <= w_winner;
            we_q    <= w_winner ? we1    : we0;
            addr_q  <= w_winner ? addr1  : addr0;
            wdata_q <= w_winner ? wdata1 : wdata0;
        end
    end

    // ------------------------------------------------------------------
    // Completion: memory read data is valid during COMPLETE, so it is
    // captured on the edge leaving COMPLETE together with the done pulse.
    // Writes leave the read-data holding registers untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            done0_q <= w_complete && (port_q == c_PORT0);
            done1_q <= w_complete && (port_q == c_PORT1);
            if (w_complete && !we_q && (port_q == c_PORT0)) begin
                rdata0_q <= mem_rdata;
            end
            if (w_complete && !we_q && (port_q == c_PORT1)) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A transaction-level
//                reference model predicts every cycle's outputs; a vector
//                table and directed sequences cover the named scenarios and
//                a randomized run exercises arbitration and data paths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DW = 8;
    localparam int AB = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AB-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_w_r, busy;
    logic [AB-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_w_r(mem_w_r), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Synchronous-read memory attached to the arbiter
    logic [DW-1:0] tb_mem [32];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_w_r) tb_mem[mem_addr] <= mem_wdata;
            else         mem_rdata        <= tb_mem[mem_addr];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    endtask

    // ------------------------------------------------------------------
    // Reference model: one outstanding transaction with a start edge; the
    // cycle offset from that edge decides grant (0), complete (1), done (2).
    // ------------------------------------------------------------------
    bit            act_v;
    int            act_s;
    bit            act_p, act_we;
    logic [AB-1:0] act_a;
    logic [DW-1:0] act_d;
    bit            ref_last;
    logic [DW-1:0] ref_rd [2];
    logic [DW-1:0] ref_mem [32];

    task automatic model_reset();
        act_v     = 1'b0;
        ref_last  = 1'b1;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
    endtask

    task automatic model_edge();
        cyc++;
        if (!rst) begin
            model_reset();
            return;
        end
        if (act_v) begin
            int d = cyc - act_s;
            if (d == 1 && act_we)  ref_mem[act_a] = act_d;
            if (d == 2 && !act_we) ref_rd[act_p] = ref_mem[act_a];
            if (d >= 3)            act_v = 1'b0;
        end
        if (!act_v && (req0 || req1)) begin
            act_p    = (req0 && req1) ? !ref_last : req1;
            act_we   = act_p ? we1    : we0;
            act_a    = act_p ? addr1  : addr0;
            act_d    = act_p ? wdata1 : wdata0;
            act_s    = cyc;
            act_v    = 1'b1;
            ref_last = act_p;
        end
    endtask

    task automatic check_all(input string tag);
        bit e_g0 = 0, e_g1 = 0, e_d0 = 0, e_d1 = 0, e_en = 0, e_wr = 0, e_busy = 0;
        int d = act_v ? (cyc - act_s) : -1;
        if (d == 0) begin
            e_g0 = !act_p; e_g1 = act_p; e_en = 1; e_wr = act_we; e_busy = 1;
        end
        if (d == 1) e_busy = 1;
        if (d == 2) begin
            e_d0 = !act_p; e_d1 = act_p;
        end
        chk($sformatf("%s gnt", tag),    {gnt1, gnt0},       {e_g1, e_g0});
        chk($sformatf("%s done", tag),   {done1, done0},     {e_d1, e_d0});
        chk($sformatf("%s en/wr", tag),  {mem_en, mem_w_r},  {e_en, e_wr});
        chk($sformatf("%s busy", tag),   busy,               e_busy);
        chk($sformatf("%s rdata0", tag), rdata0,             ref_rd[0]);
        chk($sformatf("%s rdata1", tag), rdata1,             ref_rd[1]);
        if (e_en) begin
            chk($sformatf("%s mem_addr", tag),  mem_addr,  act_a);
            chk($sformatf("%s mem_wdata", tag), mem_wdata, act_d);
        end
        if (!rst) begin
            chk($sformatf("%s rst mem_addr", tag),  mem_addr,  0);
            chk($sformatf("%s rst mem_wdata", tag), mem_wdata, 0);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) tick("reset");
        rst = 1'b1;
    endtask

    // Requesters hold until granted; grant order is recorded.
    bit gq [$];
    logic [AB-1:0] aq [$];
    task automatic drain(input string tag);
        int n = 0;
        while ((req0 || req1) && n < 30) begin
            tick(tag);
            n++;
            if (gnt0) begin gq.push_back(1'b0); aq.push_back(mem_addr); req0 = 0; end
            if (gnt1) begin gq.push_back(1'b1); aq.push_back(mem_addr); req1 = 0; end
        end
        chk($sformatf("%s drained", tag), {req1, req0}, 0);
        repeat (3) tick(tag);
    endtask

    typedef struct {
        logic r0, w0; logic [AB-1:0] a0; logic [DW-1:0] d0;
        logic [1:0] g, dn; logic en, wr, bz;
        logic [AB-1:0] ma; logic [DW-1:0] md, rd0;
    } vec_t;
    vec_t tbl [7];

    initial begin
        int cnt;
        for (int i = 0; i < 32; i++) begin
            tb_mem[i]  = 8'(i * 7 + 1);
            ref_mem[i] = 8'(i * 7 + 1);
        end

        // Reset, then 10 quiet cycles
        do_reset();
        cnt = 0;
        repeat (10) begin
            tick("quiet");
            cnt += int'(mem_en) + int'(gnt0) + int'(gnt1) + int'(done0) + int'(done1) + int'(busy);
        end
        chk("quiet activity", cnt, 0);

        // Port 0 writes 0xA5 to addr 3 then reads it back
        //          r0    w0    a0     d0      g      dn     en    wr    bz    ma     md      rd0
        tbl[0] = '{1'b1, 1'b1, 5'd3, 8'hA5, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 5'd3, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 5'd0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 5'd3, 8'h00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 5'd3, 8'h00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 5'd3, 8'h00, 8'h00};
        tbl[4] = '{1'b0, 1'b0, 5'd0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 8'h00};
        tbl[5] = '{1'b0, 1'b0, 5'd0, 8'h00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'hA5};
        tbl[6] = '{1'b0, 1'b0, 5'd0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'hA5};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d gnt", i),    {gnt1, gnt0},      tbl[i].g);
            chk($sformatf("vec%0d done", i),   {done1, done0},    tbl[i].dn);
            chk($sformatf("vec%0d en/wr", i),  {mem_en, mem_w_r}, {tbl[i].en, tbl[i].wr});
            chk($sformatf("vec%0d busy", i),   busy,              tbl[i].bz);
            chk($sformatf("vec%0d rdata0", i), rdata0,            tbl[i].rd0);
            if (tbl[i].en) begin
                chk($sformatf("vec%0d mem_addr", i),  mem_addr,  tbl[i].ma);
                chk($sformatf("vec%0d mem_wdata", i), mem_wdata, tbl[i].md);
            end
        end

        // Both ports held from reset: alternation 0,1,0,1 on addr 1,2
        do_reset();
        gq.delete(); aq.delete();
        req0 = 1; we0 = 0; addr0 = 5'd1;
        req1 = 1; we1 = 0; addr1 = 5'd2;
        repeat (12) begin
            tick("tie");
            if (gnt0) begin gq.push_back(1'b0); aq.push_back(mem_addr); end
            if (gnt1) begin gq.push_back(1'b1); aq.push_back(mem_addr); end
        end
        idle_inputs();
        repeat (3) tick("tie tail");
        chk("tie grant count", gq.size(), 4);
        if (gq.size() == 4) begin
            chk("tie order", {gq[0], gq[1], gq[2], gq[3]}, 4'b0101);
            chk("tie addrs", {aq[0], aq[1], aq[2], aq[3]}, {5'd1, 5'd2, 5'd1, 5'd2});
        end
        chk("tie rdata0", rdata0, 8'd8);
        chk("tie rdata1", rdata1, 8'd15);

        // Port 1 last served; tie on addr 31: port 0 reads old, then port 1 writes
        do_reset();
        req1 = 1; we1 = 0; addr1 = 5'd0;
        drain("prime p1");
        gq.delete(); aq.delete();
        req0 = 1; we0 = 0; addr0 = 5'd31;
        req1 = 1; we1 = 1; addr1 = 5'd31; wdata1 = 8'h3C;
        drain("raw tie");
        chk("raw grant count", gq.size(), 2);
        if (gq.size() == 2) chk("raw order", {gq[0], gq[1]}, 2'b01);
        chk("raw old value", rdata0, 8'hDA);
        req0 = 1; we0 = 0; addr0 = 5'd31;
        drain("raw reread");
        chk("raw new value", rdata0, 8'h3C);

        // Reset asserted during ACCESS of a port 1 read
        do_reset();
        req1 = 1; we1 = 0; addr1 = 5'd5;
        tick("abort grant");
        chk("abort gnt1 before reset", gnt1, 1'b1);
        req1 = 0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("abort outputs", {gnt0, gnt1, done0, done1, mem_en, mem_w_r, busy}, 0);
        check_all("abort mid");
        tick("abort hold");
        rst = 1'b1;
        cnt = 0;
        repeat (5) begin
            tick("abort after");
            cnt += int'(done1);
        end
        chk("abort no done1", cnt, 0);
        gq.delete(); aq.delete();
        req0 = 1; we0 = 0; addr0 = 5'd6;
        req1 = 1; we1 = 0; addr1 = 5'd7;
        drain("abort tie");
        chk("abort first winner", (gq.size() > 0) ? int'(gq[0]) : -1, 0);

        // req1 pulsed for one cycle while busy
        do_reset();
        req0 = 1; we0 = 0; addr0 = 5'd4;
        cnt = 0;
        tick("pulse a");
        cnt += int'(mem_en);
        req0 = 0;
        req1 = 1; we1 = 1; addr1 = 5'd9; wdata1 = 8'h77;
        tick("pulse b");
        cnt += int'(mem_en) + 2 * int'(gnt1);
        req1 = 0;
        repeat (6) begin
            tick("pulse c");
            cnt += int'(mem_en) + 2 * int'(gnt1);
        end
        chk("pulse accesses", cnt, 1);

        // Randomized traffic against the reference model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (!req0) begin
                if ($urandom_range(0, 2) == 0) begin
                    req0 = 1; we0 = 1'($urandom_range(0, 1));
                    addr0 = 5'($urandom_range(0, 7)); wdata0 = 8'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) req0 = 0;
            if (!req1) begin
                if ($urandom_range(0, 2) == 0) begin
                    req1 = 1; we1 = 1'($urandom_range(0, 1));
                    addr1 = 5'($urandom_range(0, 7)); wdata1 = 8'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) req1 = 0;
            tick("rand");
            if (act_v && act_s == cyc) begin
                if (act_p) req1 = 0;
                else       req0 = 0;
            end
        end
        idle_inputs();
        repeat (4) tick("rand tail");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, data word width; ADDR_BITS, default 5, data-memory address width (32 words).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 req0, req1  input  1 each  access request from port 0 (control unit) and port 1 (loader/host).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read, qualified by reqN.
REQ-006 addr0, addr1  input  ADDR_BITS each  word address.
REQ-007 wdata0, wdata1  input  DATA_WIDTH each  write data.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 rdata0, rdata1  output  DATA_WIDTH each  per-port read data, held until that port's next read completes.
REQ-011 mem_en, mem_w_r  output  1 each  memory enable; 1 = write.
REQ-012 mem_addr, mem_wdata  output  ADDR_BITS, DATA_WIDTH  memory address and write data.
REQ-013 mem_rdata  input  DATA_WIDTH  synchronous-read memory data, valid the cycle after mem_en with mem_w_r=0.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, COMPLETE; any other encoding SHALL return to IDLE next cycle.
REQ-016 IDLE: if any reqN is high at the rising edge, pick a winner, latch its we/addr/wdata and go to ACCESS; otherwise stay.
REQ-017 Winner: single requester wins; if both are high, the port not served last wins (round-robin); the last-served pointer updates on each grant.
REQ-018 ACCESS: gntW=1, mem_en=1, mem_w_r=latched we, mem_addr/mem_wdata = latched values; next state COMPLETE.
REQ-019 COMPLETE: mem_en=0; for reads, rdataW is registered from mem_rdata at the end of this cycle; doneW goes high for exactly the following cycle; next state IDLE.
REQ-020 Latency: request sampled at edge E0 -> gnt in the cycle after E0 -> done in the cycle after E2; throughput is one access per 3 cycles.
REQ-021 In IDLE, ACCESS and COMPLETE, mem_en, gnt* and done* SHALL be 0 except as stated in REQ-018 and REQ-019.
REQ-022 Requesters hold reqN and operands until gntN; requests seen while busy are not sampled and no access is lost while the request stays held.
REQ-023 reqN dropped before sampling -> no access and no gnt; reqN still high in the done cycle -> treated as a new request at the next IDLE sample.
REQ-024 Writes never change rdataN; done still pulses for writes.
REQ-025 Ports are never granted simultaneously; at most one mem_en per 3 cycles.

Reset
REQ-026 While rst=0: state=IDLE; gnt*, done*, mem_en, mem_w_r, busy = 0; mem_addr, mem_wdata, rdata* = 0; last-served pointer = port 1, so port 0 wins the first tie.
REQ-027 Reset mid-access aborts immediately: no done pulse, latched operands discarded.

Structure
REQ-028 A shared package mem_arb_pkg SHALL hold the state enumeration and the DATA_WIDTH/ADDR_BITS defaults.
REQ-029 One sub-module rr_pick SHALL be used: combinational 2-way round-robin picker (inputs req0, req1, last; outputs winner and valid).

Verification
REQ-030 Reset release, no requests for 10 cycles -> mem_en, gnt*, done*, busy stay 0.
REQ-031 Port 0 writes 0xA5 to addr 3, then reads addr 3 -> one mem_en write cycle, then rdata0=0xA5 with done0 exactly 3 cycles after the read is sampled.
REQ-032 req0 and req1 both held from reset (reads of addr 1 and addr 2) -> grant order 0,1,0,1; mem_addr alternates 1,2.
REQ-033 Port 1 writes 0x3C to addr 31 while port 0 reads addr 31 in the same sampling cycle after port 1 was last served -> port 0 is served first and reads the old value; port 1 write follows; a second port 0 read returns 0x3C.
REQ-034 rst asserted during ACCESS of a port 1 read -> no done1, all outputs 0 within the same cycle, and port 0 wins the first tie after release.
REQ-035 req1 pulsed for one cycle while busy -> no gnt1 and no memory access for port 1.
